// File: rtl/seg7_scan_bcd.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_bcd
// Purpose  : NUM_CH binary values -> double-dabble BCD -> atomic snapshot ->
//            scanned active-low anode/segment bus. Define SEG7_LZB_EN for
//            leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_bcd #(
   parameter int NUM_CH   = 2,
   parameter int VAL_W    = 8,
   parameter int DIGITS   = 3,
   parameter int AN_W     = 8,
   parameter int SCAN_DIV = 25000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*VAL_W-1:0] i_val,
   input  logic                    i_hold,
   output logic [AN_W-1:0]         o_an,
   output logic [6:0]              o_seg7,
   output logic [NUM_CH-1:0]       o_ovf,
   output logic                    o_upd
);

   localparam int c_BCD_W = DIGITS * 4;
   localparam int c_NSLOT = NUM_CH * DIGITS;
   localparam int c_CH_W  = (NUM_CH > 1)   ? $clog2(NUM_CH)   : 1;
   localparam int c_DG_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
   localparam int c_IDX_W = (c_NSLOT > 1)  ? $clog2(c_NSLOT)  : 1;
   localparam int c_BC_W  = $clog2(VAL_W + 1);
   localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [c_CH_W-1:0]  c_CH_LAST  = c_CH_W'(NUM_CH - 1);
   localparam logic [c_CH_W-1:0]  c_CH_ONE   = c_CH_W'(1);
   localparam logic [c_DG_W-1:0]  c_DG_LAST  = c_DG_W'(DIGITS - 1);
   localparam logic [c_DG_W-1:0]  c_DG_ONE   = c_DG_W'(1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NSLOT - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
   localparam logic [c_BC_W-1:0]  c_BC_INIT  = c_BC_W'(VAL_W);
   localparam logic [c_BC_W-1:0]  c_BC_ONE   = c_BC_W'(1);
   localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
   localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
   localparam logic [AN_W-1:0]    c_AN_ONE   = AN_W'(1);
   localparam logic [6:0]         c_SEG_OFF  = 7'b1111111;
   localparam logic [6:0]         c_SEG_DASH = 7'b0111111;

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_SHIFT  = 2'd1,
      S_STORE  = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_CH_W-1:0]    r_ch;
   logic [VAL_W-1:0]     r_sr;
   logic [c_BCD_W-1:0]   r_bcd;
   logic [c_BC_W-1:0]    r_bitcnt;
   logic                 r_ovf_acc;
   logic [c_BCD_W-1:0]   r_pend [NUM_CH];
   logic [NUM_CH-1:0]    r_pend_ovf;
   logic [c_BCD_W-1:0]   r_snap [NUM_CH];
   logic [NUM_CH-1:0]    r_ovf;
   logic                 r_upd;

   logic [c_PRE_W-1:0]   r_pre;
   logic [c_IDX_W-1:0]   r_idx;
   logic [c_CH_W-1:0]    r_sch;
   logic [c_DG_W-1:0]    r_sdig;
   logic [AN_W-1:0]      r_an;
   logic [6:0]           r_seg;

   logic [VAL_W-1:0]     w_val [NUM_CH];
   logic [c_BCD_W-1:0]   w_adj;
   logic [c_BCD_W-1:0]   w_cur;
   logic [c_BCD_W-1:0]   w_hi;
   logic [AN_W-1:0]      w_an;
   logic [6:0]           w_seg;

   for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_unpack
      assign w_val[gc] = i_val[gc*VAL_W +: VAL_W];
   end

   for (genvar gd = 0; gd < DIGITS; gd++) begin : g_adj
      assign w_adj[gd*4 +: 4] = (r_bcd[gd*4 +: 4] >= 4'd5) ? (r_bcd[gd*4 +: 4] + 4'd3)
                                                           : r_bcd[gd*4 +: 4];
   end

   function automatic logic [6:0] f_seg(input logic [3:0] i_nib);
      case (i_nib)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Converter: one channel per LOAD/SHIFT*VAL_W/STORE pass, then one COMMIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_LOAD;
         r_ch       <= '0;
         r_sr       <= '0;
         r_bcd      <= '0;
         r_bitcnt   <= '0;
         r_ovf_acc  <= 1'b0;
         r_pend_ovf <= '0;
         r_ovf      <= '0;
         r_upd      <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_pend[c] <= '0;
            r_snap[c] <= '0;
         end
      end else begin
         r_upd <= 1'b0;
         case (r_state)
            S_LOAD: begin
               r_sr      <= w_val[r_ch];
               r_bcd     <= '0;
               r_bitcnt  <= c_BC_INIT;
               r_ovf_acc <= 1'b0;
               r_state   <= S_SHIFT;
            end
            S_SHIFT: begin
               {r_bcd, r_sr} <= {w_adj[c_BCD_W-2:0], r_sr, 1'b0};
               r_ovf_acc     <= r_ovf_acc | w_adj[c_BCD_W-1];
               r_bitcnt      <= r_bitcnt - c_BC_ONE;
               if (r_bitcnt == c_BC_ONE) begin
                  r_state <= S_STORE;
               end
            end
            S_STORE: begin
               r_pend[r_ch]     <= r_bcd;
               r_pend_ovf[r_ch] <= r_ovf_acc;
               if (r_ch == c_CH_LAST) begin
                  r_state <= S_COMMIT;
               end else begin
                  r_ch    <= r_ch + c_CH_ONE;
                  r_state <= S_LOAD;
               end
            end
            S_COMMIT: begin
               if (!i_hold) begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     r_snap[c] <= r_pend[c];
                  end
                  r_ovf <= r_pend_ovf;
                  r_upd <= 1'b1;
               end
               r_ch    <= '0;
               r_state <= S_LOAD;
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

   // Nibbles from the current digit upward; zero means this digit is a leading zero.
   always_comb begin
      w_cur = r_snap[r_sch];
      w_hi  = w_cur >> {r_sdig, 2'b00};
      w_an  = ~(c_AN_ONE << r_idx);
   end

   always_comb begin
      if (r_ovf[r_sch]) begin
         w_seg = c_SEG_DASH;
      end
`ifdef SEG7_LZB_EN
      else if ((r_sdig != '0) && (w_hi == '0)) begin
         w_seg = c_SEG_OFF;
      end
`endif
      else begin
         w_seg = f_seg(w_hi[3:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre  <= '0;
         r_idx  <= '0;
         r_sch  <= '0;
         r_sdig <= '0;
         r_an   <= '1;
         r_seg  <= c_SEG_OFF;
      end else if (r_pre == c_PRE_LAST) begin
         r_pre <= '0;
         r_an  <= w_an;
         r_seg <= w_seg;
         if (r_idx == c_IDX_LAST) begin
            r_idx  <= '0;
            r_sch  <= '0;
            r_sdig <= '0;
         end else begin
            r_idx <= r_idx + c_IDX_ONE;
            if (r_sdig == c_DG_LAST) begin
               r_sdig <= '0;
               r_sch  <= r_sch + c_CH_ONE;
            end else begin
               r_sdig <= r_sdig + c_DG_ONE;
            end
         end
      end else begin
         r_pre <= r_pre + c_PRE_ONE;
      end
   end

   assign o_an   = r_an;
   assign o_seg7 = r_seg;
   assign o_ovf  = r_ovf;
   assign o_upd  = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_bcd.sv
`default_nettype none
// tb_seg7_scan_bcd: scoreboard bench driving a 3-digit and a 2-digit instance
// (SCAN_DIV=4) from shared inputs and comparing each scan slot against a decimal model.
module tb_seg7_scan_bcd;
   localparam int SD = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] val   = '0;
   logic        hold  = 1'b0;
   logic [7:0]  an1, an2;
   logic [6:0]  seg1, seg2;
   logic [1:0]  ovf1, ovf2;
   logic        upd1, upd2;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_upd;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
   } exp_t;
   exp_t sb[$];

   seg7_scan_bcd #(.NUM_CH(2), .VAL_W(8), .DIGITS(3), .AN_W(8), .SCAN_DIV(SD)) u1 (
      .clk(clk), .rst_n(rst_n), .i_val(val), .i_hold(hold),
      .o_an(an1), .o_seg7(seg1), .o_ovf(ovf1), .o_upd(upd1));

   seg7_scan_bcd #(.NUM_CH(2), .VAL_W(8), .DIGITS(2), .AN_W(8), .SCAN_DIV(SD)) u2 (
      .clk(clk), .rst_n(rst_n), .i_val(val), .i_hold(hold),
      .o_an(an2), .o_seg7(seg2), .o_ovf(ovf2), .o_upd(upd2));

   always #5 clk = ~clk;

   // Edges since reset release: edge k leaves cyc == k.
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pow10(input int n);
      int r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] m_digit(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] m_slot(input int v, input int nd, input int i);
      if (v >= pow10(nd)) return 7'b0111111;
`ifdef SEG7_LZB_EN
      if ((i > 0) && (v < pow10(i))) return 7'b1111111;
`endif
      return m_digit((v / pow10(i)) % 10);
   endfunction

   function automatic logic [1:0] m_ovf(input int v0, input int v1, input int nd);
      return {(v1 >= pow10(nd)), (v0 >= pow10(nd))};
   endfunction

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic push_frame(input int v0, input int v1, input int nd);
      exp_t e;
      for (int s = 0; s < 2*nd; s++) begin
         e.an  = ~(8'd1 << s);
         e.seg = m_slot((s / nd == 0) ? v0 : v1, nd, s % nd);
         sb.push_back(e);
      end
   endtask

   // Waits past at least two commits, then checks one full scan frame from slot 0.
   task automatic run_frame(input string tag, input int sel, input int nd);
      int   per;
      int   t;
      exp_t e;
      per = SD * 2 * nd;
      t   = cyc + 43;
      while ((t % per) != SD) t++;
      for (int s = 0; s < 2*nd; s++) begin
         wait_cyc(t + SD*s);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
         end else begin
            e = sb.pop_front();
            chk({tag, "_an"},  (sel != 0) ? an2  : an1,  e.an);
            chk({tag, "_seg"}, (sel != 0) ? seg2 : seg1, e.seg);
         end
      end
   endtask

   task automatic count_upd(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (upd1) cnt++;
      end
   endtask

   task automatic check_first_upd(input string tag);
      wait_cyc(20);
      chk({tag, "_upd_c20"}, upd1, 1'b0);
      chk({tag, "_upd2_c20"}, upd2, 1'b0);
      wait_cyc(21);
      chk({tag, "_upd_c21"}, upd1, 1'b1);
      chk({tag, "_upd2_c21"}, upd2, 1'b1);
      wait_cyc(22);
      chk({tag, "_upd_c22"}, upd1, 1'b0);
      chk({tag, "_ovf"},  ovf1, m_ovf(int'(val[7:0]), int'(val[15:8]), 3));
      chk({tag, "_ovf2"}, ovf2, m_ovf(int'(val[7:0]), int'(val[15:8]), 2));
   endtask

   initial begin
      rst_n = 1'b0;
      hold  = 1'b0;
      val   = {8'd123, 8'd45};
      repeat (3) @(negedge clk);
      chk("rst_an",   an1,  8'hFF);
      chk("rst_seg",  seg1, 7'h7F);
      chk("rst_upd",  upd1, 1'b0);
      chk("rst_ovf",  ovf1, 2'b00);
      chk("rst_an2",  an2,  8'hFF);
      chk("rst_seg2", seg2, 7'h7F);

      rst_n = 1'b1;
      wait_cyc(3);
      chk("pretick_an", an1, 8'hFF);
      wait_cyc(4);
      chk("tick0_an",  an1,  8'hFE);
      chk("tick0_seg", seg1, 7'b1000000);
      check_first_upd("init");
      push_frame(45, 123, 3);
      run_frame("init", 0, 3);

      hold     = 1'b1;
      val[7:0] = 8'd200;
      count_upd(70, n_upd);
      chk("hold_upd_cnt", n_upd, 0);
      push_frame(45, 123, 3);
      run_frame("hold", 0, 3);
      hold = 1'b0;
      count_upd(21, n_upd);
      chk("release_upd_cnt", n_upd, 1);
      push_frame(200, 123, 3);
      run_frame("release", 0, 3);

      val[7:0] = 8'd255;
      push_frame(255, 123, 3);
      run_frame("max", 0, 3);
      chk("max_ovf", ovf1, 2'b00);

      val[7:0] = 8'd7;
      push_frame(7, 123, 3);
      run_frame("lz7", 0, 3);

      val[7:0] = 8'd0;
      push_frame(0, 123, 3);
      run_frame("zero", 0, 3);

      val[7:0] = 8'd100;
      push_frame(100, 123, 3);
      run_frame("d3_100", 0, 3);
      push_frame(100, 123, 2);
      run_frame("d2_100", 1, 2);
      chk("d2_100_ovf", ovf2, m_ovf(100, 123, 2));

      val[7:0] = 8'd99;
      push_frame(99, 123, 2);
      run_frame("d2_99", 1, 2);
      chk("d2_99_ovf", ovf2, m_ovf(99, 123, 2));

      // Land in SHIFT of channel 1, between scan ticks.
      @(negedge clk);
      while ((cyc % 21) != 14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_an",   an1,  8'hFF);
      chk("midrst_seg",  seg1, 7'h7F);
      chk("midrst_upd",  upd1, 1'b0);
      chk("midrst_ovf2", ovf2, 2'b00);
      chk("midrst_an2",  an2,  8'hFF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_first_upd("rerun");
      push_frame(99, 123, 3);
      run_frame("rerun", 0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
